// File: rtl/sm83_pkg.sv
// sm83_pkg: shared types and constants for the SM83 external bus controller.
//   sm83_bus_op_t    - access kind latched at T1 (IDLE / READ / WRITE)
//   sm83_bus_state_t - bus FSM state (RUN follows T-strobes, WAIT extends T4)
//   WAIT_CNT_W       - width of the wait-state counter
//   WAIT_MAX         - wait count at which a stalled access is forced to end
package sm83_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } sm83_bus_op_t;

    typedef enum logic {
        RUN,
        WAIT
    } sm83_bus_state_t;

    localparam int unsigned                 WAIT_CNT_W = 4;
    localparam logic [WAIT_CNT_W-1:0]       WAIT_MAX   = 4'd15;

endpackage

// File: rtl/sm83_bus_wait_timer.sv
// sm83_bus_wait_timer: wait-state counter for the SM83 bus controller.
// Only instantiated when SM83_BUS_WAIT_EN is defined.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   inc        - count one more wait cycle (holds at WAIT_MAX)
//   clr        - return the count to zero (wins over inc)
//   sat        - count has reached WAIT_MAX
module sm83_bus_wait_timer
    import sm83_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != WAIT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == WAIT_MAX);

endmodule

// File: rtl/sm83_bus_ctrl.sv
// sm83_bus_ctrl: external memory bus driver for one access per SM83 M-cycle.
// Latches the core request at T1, drives address/strobes/data enable T2..T4,
// returns read data and generates ncyc, the sequencer restart for the next T1.
// Optional feature macro: SM83_BUS_WAIT_EN (ext_wait stretches T4 via a WAIT
// state, with forced exit and bus_err after WAIT_MAX wait cycles).
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   t1..t4, m1           - T-state strobes and opcode-fetch flag from sequencer
//   req_rd/req_wr        - access request (write wins), sampled in T1
//   req_addr, req_wdata  - access address / write data, sampled in T1
//   ext_wait, d_in       - bus wait request, external read data
//   a, d_out, d_oe       - external address, write data, data output enable
//   nrd, nwr             - active-low read / write strobes
//   fetch                - current access is an opcode fetch
//   rdata, rdata_valid   - last read data and its one-cycle update pulse
//   bus_err              - one-cycle wait-timeout pulse
//   ncyc                 - combinational restart request to the sequencer
module sm83_bus_ctrl
    import sm83_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          t1,
    input  logic          t2,
    input  logic          t3,
    input  logic          t4,
    input  logic          m1,
    input  logic          req_rd,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic          ext_wait,
    input  logic [DW-1:0] d_in,
    output logic [AW-1:0] a,
    output logic [DW-1:0] d_out,
    output logic          d_oe,
    output logic          nrd,
    output logic          nwr,
    output logic          fetch,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic          bus_err,
    output logic          ncyc
);

    sm83_bus_op_t    op_q, op_d;
    sm83_bus_state_t state_q, state_d;

    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] d_out_q, d_out_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          d_oe_q, d_oe_d;
    logic          nrd_q, nrd_d;
    logic          nwr_q, nwr_d;
    logic          fetch_q, fetch_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          bus_err_q, bus_err_d;

    logic stall;
    logic timeout;
    logic last_cyc;

`ifdef SM83_BUS_WAIT_EN
    logic wt_sample;
    logic wt_sat;

    // ext_wait only matters in T4 and in WAIT; the counter holds at WAIT_MAX,
    // so a saturated count with ext_wait still high is the timeout condition.
    assign wt_sample = ((state_q == RUN) && t4) || (state_q == WAIT);
    assign stall     = ext_wait & ~wt_sat;
    assign timeout   = ext_wait & wt_sat;

    sm83_bus_wait_timer u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .inc   (wt_sample & stall),
        .clr   (wt_sample & ~stall),
        .sat   (wt_sat)
    );
`else
    logic unused_ext_wait;

    assign unused_ext_wait = ext_wait;
    assign stall           = 1'b0;
    assign timeout         = 1'b0;
`endif

    // Final cycle of the access: T4 or a WAIT cycle that is not stalled.
    assign last_cyc = (((state_q == RUN) && t4) || (state_q == WAIT)) && !stall;
    assign ncyc     = reset | last_cyc;

    always_comb begin
        op_d          = op_q;
        state_d       = state_q;
        a_d           = a_q;
        d_out_d       = d_out_q;
        rdata_d       = rdata_q;
        d_oe_d        = d_oe_q;
        nrd_d         = nrd_q;
        nwr_d         = nwr_q;
        fetch_d       = fetch_q;
        rdata_valid_d = 1'b0;
        bus_err_d     = 1'b0;

        if ((state_q == RUN) && t1) begin
            if (req_wr) begin
                op_d = WRITE;
            end else if (req_rd) begin
                op_d = READ;
            end else begin
                op_d = IDLE;
            end
            if (req_wr || req_rd) begin
                a_d     = req_addr;
                d_out_d = req_wdata;
                fetch_d = m1;
            end
            nrd_d  = !(req_rd && !req_wr);
            d_oe_d = req_wr;
        end

        if ((state_q == RUN) && t2 && (op_q == WRITE)) begin
            nwr_d = 1'b0;
        end

        if (t3) begin
            nwr_d = 1'b1;
        end

        if ((state_q == RUN) && t4 && stall) begin
            state_d = WAIT;
        end

        if (last_cyc) begin
            state_d   = RUN;
            op_d      = IDLE;
            nrd_d     = 1'b1;
            d_oe_d    = 1'b0;
            bus_err_d = timeout;
            if (op_q == READ) begin
                rdata_d       = d_in;
                rdata_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q          <= IDLE;
            state_q       <= RUN;
            a_q           <= '0;
            d_out_q       <= '0;
            rdata_q       <= '0;
            d_oe_q        <= 1'b0;
            nrd_q         <= 1'b1;
            nwr_q         <= 1'b1;
            fetch_q       <= 1'b0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            op_q          <= op_d;
            state_q       <= state_d;
            a_q           <= a_d;
            d_out_q       <= d_out_d;
            rdata_q       <= rdata_d;
            d_oe_q        <= d_oe_d;
            nrd_q         <= nrd_d;
            nwr_q         <= nwr_d;
            fetch_q       <= fetch_d;
            rdata_valid_q <= rdata_valid_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign a           = a_q;
    assign d_out       = d_out_q;
    assign d_oe        = d_oe_q;
    assign nrd         = nrd_q;
    assign nwr         = nwr_q;
    assign fetch       = fetch_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_sm83_bus_ctrl.sv
// tb_sm83_bus_ctrl: directed self-checking bench for sm83_bus_ctrl.
// The bench plays the sequencer, driving one-hot T-strobes cycle by cycle,
// and checks bus outputs against hand-computed values. Inputs change 1 time
// unit after the rising edge; outputs are checked 1 unit later.
module tb_sm83_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        t1, t2, t3, t4, m1;
    logic        req_rd, req_wr;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        ext_wait;
    logic [7:0]  d_in;
    logic [15:0] a;
    logic [7:0]  d_out;
    logic        d_oe, nrd, nwr, fetch;
    logic [7:0]  rdata;
    logic        rdata_valid, bus_err, ncyc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sm83_bus_ctrl #(.AW(16), .DW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .t1          (t1),
        .t2          (t2),
        .t3          (t3),
        .t4          (t4),
        .m1          (m1),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .ext_wait    (ext_wait),
        .d_in        (d_in),
        .a           (a),
        .d_out       (d_out),
        .d_oe        (d_oe),
        .nrd         (nrd),
        .nwr         (nwr),
        .fetch       (fetch),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .bus_err     (bus_err),
        .ncyc        (ncyc)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // strobes = {t4,t3,t2,t1}
    task automatic next_cyc(input logic [3:0] strobes);
        @(posedge clk);
        #1;
        {t4, t3, t2, t1} = strobes;
    endtask

    initial begin
        reset = 1'b1; {t4, t3, t2, t1} = 4'b0000; m1 = 1'b0;
        req_rd = 1'b0; req_wr = 1'b0; req_addr = 16'h0000; req_wdata = 8'h00;
        ext_wait = 1'b0; d_in = 8'h00;

        // ---------------- reset held for 3 cycles ----------------
        next_cyc(4'b0000); #1;
        chk1("rst_ncyc_c1", ncyc, 1'b1);
        next_cyc(4'b0001); req_wr = 1'b1; req_addr = 16'h1234; req_wdata = 8'hEE; #1;
        chk1("rst_ncyc_c2", ncyc, 1'b1);
        next_cyc(4'b0000); req_wr = 1'b0; #1;
        chk1("rst_ncyc_c3", ncyc, 1'b1);
        chk16("rst_a", a, 16'h0000);
        chk16("rst_d_out", {8'h00, d_out}, 16'h0000);
        chk1("rst_d_oe", d_oe, 1'b0);
        chk1("rst_nrd", nrd, 1'b1);
        chk1("rst_nwr", nwr, 1'b1);
        chk1("rst_fetch", fetch, 1'b0);
        chk16("rst_rdata", {8'h00, rdata}, 16'h0000);
        chk1("rst_rvalid", rdata_valid, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);

        // ---------------- READ 0xC000, d_in=0x5A ----------------
        next_cyc(4'b0001); reset = 1'b0; req_rd = 1'b1; req_addr = 16'hC000; #1;
        chk1("rd_t1_ncyc", ncyc, 1'b0);
        chk1("rd_t1_nrd", nrd, 1'b1);
        next_cyc(4'b0010); req_rd = 1'b0; req_addr = 16'h0000; #1;
        chk16("rd_t2_a", a, 16'hC000);
        chk1("rd_t2_nrd", nrd, 1'b0);
        chk1("rd_t2_d_oe", d_oe, 1'b0);
        chk1("rd_t2_fetch", fetch, 1'b0);
        next_cyc(4'b0100); #1;
        chk1("rd_t3_nrd", nrd, 1'b0);
        chk1("rd_t3_nwr", nwr, 1'b1);
        next_cyc(4'b1000); d_in = 8'h5A; ext_wait = 1'b0; #1;
        chk1("rd_t4_nrd", nrd, 1'b0);
        chk1("rd_t4_ncyc", ncyc, 1'b1);
        chk1("rd_t4_rvalid", rdata_valid, 1'b0);

        // ---------------- WRITE 0xFF40 <- 0x91 (back-to-back) ----------------
        next_cyc(4'b0001); d_in = 8'h00; req_wr = 1'b1; req_addr = 16'hFF40; req_wdata = 8'h91; #1;
        chk16("rd_rdata", {8'h00, rdata}, 16'h005A);
        chk1("rd_rvalid_n4", rdata_valid, 1'b1);
        chk1("rd_nrd_released", nrd, 1'b1);
        chk1("wr_t1_ncyc", ncyc, 1'b0);
        next_cyc(4'b0010); req_wr = 1'b0; req_wdata = 8'h00; #1;
        chk16("wr_t2_a", a, 16'hFF40);
        chk16("wr_t2_d_out", {8'h00, d_out}, 16'h0091);
        chk1("wr_t2_d_oe", d_oe, 1'b1);
        chk1("wr_t2_nwr", nwr, 1'b1);
        chk1("wr_t2_nrd", nrd, 1'b1);
        chk1("wr_t2_rvalid", rdata_valid, 1'b0);
        next_cyc(4'b0100); #1;
        chk1("wr_t3_nwr", nwr, 1'b0);
        chk1("wr_t3_d_oe", d_oe, 1'b1);
        next_cyc(4'b1000); #1;
        chk1("wr_t4_nwr", nwr, 1'b1);
        chk1("wr_t4_d_oe", d_oe, 1'b1);
        chk1("wr_t4_ncyc", ncyc, 1'b1);

        // ---------------- rd+wr on M1 fetch -> WRITE, fetch=1 ----------------
        next_cyc(4'b0001); req_rd = 1'b1; req_wr = 1'b1; m1 = 1'b1;
        req_addr = 16'h0150; req_wdata = 8'h3C; #1;
        chk1("wr_after_d_oe", d_oe, 1'b0);
        chk1("wr_no_rvalid", rdata_valid, 1'b0);
        chk16("wr_rdata_kept", {8'h00, rdata}, 16'h005A);
        next_cyc(4'b0010); req_rd = 1'b0; req_wr = 1'b0; m1 = 1'b0; #1;
        chk1("both_fetch", fetch, 1'b1);
        chk16("both_a", a, 16'h0150);
        chk16("both_d_out", {8'h00, d_out}, 16'h003C);
        chk1("both_d_oe", d_oe, 1'b1);
        chk1("both_nrd", nrd, 1'b1);
        next_cyc(4'b0100); #1;
        chk1("both_t3_nwr", nwr, 1'b0);
        chk1("both_t3_nrd", nrd, 1'b1);
`ifdef SM83_BUS_WAIT_EN
        next_cyc(4'b1000); #1;
`else
        // ext_wait has no effect in this build
        next_cyc(4'b1000); ext_wait = 1'b1; #1;
        chk1("nowait_t4_ncyc", ncyc, 1'b1);
`endif
        chk1("both_t4_nwr", nwr, 1'b1);
        chk1("both_t4_d_oe", d_oe, 1'b1);

        // ---------------- IDLE M-cycle ----------------
        next_cyc(4'b0001); ext_wait = 1'b0; req_addr = 16'h9999; req_wdata = 8'h77; #1;
        chk1("idle_t1_d_oe", d_oe, 1'b0);
        chk1("both_no_rvalid", rdata_valid, 1'b0);
        chk1("nowait_bus_err", bus_err, 1'b0);
        next_cyc(4'b0010); #1;
        chk16("idle_a", a, 16'h0150);
        chk16("idle_d_out", {8'h00, d_out}, 16'h003C);
        chk1("idle_fetch", fetch, 1'b1);
        chk1("idle_nrd", nrd, 1'b1);
        chk1("idle_d_oe", d_oe, 1'b0);
        next_cyc(4'b0100); #1;
        chk1("idle_t3_nwr", nwr, 1'b1);
        next_cyc(4'b1000); #1;
        chk1("idle_t4_ncyc", ncyc, 1'b1);
        chk1("idle_t4_nrd", nrd, 1'b1);

`ifdef SM83_BUS_WAIT_EN
        // ---------------- READ with ext_wait for 2 cycles (W=2) ----------------
        next_cyc(4'b0001); req_rd = 1'b1; req_addr = 16'h8000; #1;
        chk1("idle_rvalid", rdata_valid, 1'b0);
        next_cyc(4'b0010); req_rd = 1'b0; #1;
        next_cyc(4'b0100); #1;
        next_cyc(4'b1000); ext_wait = 1'b1; #1;
        chk1("w2_t4_ncyc", ncyc, 1'b0);
        next_cyc(4'b0000); #1;
        chk1("w2_wait1_ncyc", ncyc, 1'b0);
        chk1("w2_wait1_nrd", nrd, 1'b0);
        next_cyc(4'b0000); ext_wait = 1'b0; d_in = 8'hA5; #1;
        chk1("w2_wait2_ncyc", ncyc, 1'b1);
        chk1("w2_wait2_nrd", nrd, 1'b0);
        chk1("w2_wait2_rvalid", rdata_valid, 1'b0);

        // ---------------- READ with ext_wait held: timeout ----------------
        next_cyc(4'b0001); d_in = 8'h00; req_rd = 1'b1; req_addr = 16'h8001; #1;
        chk1("w2_rvalid_n6", rdata_valid, 1'b1);
        chk16("w2_rdata", {8'h00, rdata}, 16'h00A5);
        chk1("w2_bus_err", bus_err, 1'b0);
        next_cyc(4'b0010); req_rd = 1'b0; #1;
        next_cyc(4'b0100); #1;
        next_cyc(4'b1000); ext_wait = 1'b1; #1;
        chk1("to_t4_ncyc", ncyc, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            next_cyc(4'b0000);
            if (i == 15) d_in = 8'hC3;
            #1;
            chk1("to_wait_ncyc", ncyc, (i == 15));
            chk1("to_wait_nrd", nrd, 1'b0);
            chk1("to_wait_rvalid", rdata_valid, 1'b0);
        end
        next_cyc(4'b0001); ext_wait = 1'b0; d_in = 8'h00; #1;
        chk1("to_bus_err", bus_err, 1'b1);
        chk1("to_rvalid", rdata_valid, 1'b1);
        chk16("to_rdata", {8'h00, rdata}, 16'h00C3);
        chk1("to_nrd_released", nrd, 1'b1);
        next_cyc(4'b0010); #1;
        chk1("to_bus_err_pulse", bus_err, 1'b0);
        next_cyc(4'b0100); #1;
        next_cyc(4'b1000); #1;
        chk1("to_idle_t4_ncyc", ncyc, 1'b1);
`endif

        // ---------------- reset asserted in T3 of a WRITE ----------------
        next_cyc(4'b0001); req_wr = 1'b1; req_addr = 16'h1234; req_wdata = 8'h55; #1;
        next_cyc(4'b0010); req_wr = 1'b0; #1;
        chk1("rw_t2_d_oe", d_oe, 1'b1);
        next_cyc(4'b0100); reset = 1'b1; #1;
        chk1("rw_t3_nwr", nwr, 1'b0);
        chk1("rw_t3_ncyc", ncyc, 1'b1);
        next_cyc(4'b1000); #1;
        chk1("rw_rst_nwr", nwr, 1'b1);
        chk1("rw_rst_d_oe", d_oe, 1'b0);
        chk1("rw_rst_rvalid", rdata_valid, 1'b0);
        chk1("rw_rst_ncyc", ncyc, 1'b1);
        next_cyc(4'b0001); reset = 1'b0; #1;
        chk1("rw_rel_t1_ncyc", ncyc, 1'b0);
        chk16("rw_rel_a", a, 16'h0000);
        next_cyc(4'b0010); #1;
        chk1("rw_idle_d_oe", d_oe, 1'b0);
        chk1("rw_idle_nwr", nwr, 1'b1);
        chk1("rw_idle_rvalid", rdata_valid, 1'b0);
        next_cyc(4'b0100); #1;
        chk1("rw_idle_t3_nwr", nwr, 1'b1);
        next_cyc(4'b1000); #1;
        chk1("rw_idle_t4_ncyc", ncyc, 1'b1);
        next_cyc(4'b0000); #1;
        chk1("rw_end_rvalid", rdata_valid, 1'b0);
        chk1("rw_end_d_oe", d_oe, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
